cayde_alu_mdu: RTL
==================

// Module: cayde_alu_mdu
// PURPOSE
// Parametrised execute unit for cayde: decodes ALUop/funct7/funct3 internally and
// computes RV32I/RV64I integer ops plus the RV M-extension (MUL*/DIV*/REM*).
// Sits between decode and writeback. Single-cycle ALU ops. Iterative multiply and divide.
// Uses a valid/ready handshake on both sides so the pipeline stalls on multi-cycle ops.
// PARAMETERS
// XLEN   32  operand/result width; legal values 32 or 64
// M_EXT  1   1 = M-extension ops enabled; 0 = funct7=0000001 decodes as illegal
// PORTS
// clk          in   1     clock, rising edge
// rst          in   1     synchronous reset, active-high
// in_valid     in   1     operation request
// in_ready     out  1     unit can accept; high only in IDLE
// ALUop        in   2     00 ADD (ld/st addr), 01 SUB (branch), 10 R-type, 11 I-type
// funct7       in   7     instruction funct7
// funct3       in   3     instruction funct3
// a            in   XLEN  operand rs1
// b            in   XLEN  operand rs2 / immediate
// out_valid    out  1     result available; held until out_ready
// out_ready    in   1     consumer accepts result
// result       out  XLEN  result; stable while out_valid
// out_illegal  out  1     op undecodable; result=0, qualified by out_valid
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=1 next cycle; out_valid=0, result=0, out_illegal=0.
// - Reset mid-operation aborts the op. No result is emitted.
// - FSM states: IDLE, MUL, DIV, DONE. in_ready = (state==IDLE).
// - Accept when in_valid&&in_ready at edge k. Operands, decoded op and signs are latched.
// - Decode rules:
//   - 10: f7=0000000 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by f3.
//   - 10: f7=0100000 -> SUB (f3=000) or SRA (f3=101).
//   - 10: f7=0000001 -> MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//   - 10: anything else -> illegal.
//   - 11: f3 selects ADDI..ANDI. f7 is ignored except on shifts.
//   - 11 shifts: f3=001 needs f7=0000000; f3=101 takes f7 0000000 (SRLI) or 0100000 (SRAI).
//     Other f7 on 11 shifts -> illegal.
// - Shift amount = b[$clog2(XLEN)-1:0]. SLT is signed; SLTU is unsigned. Arithmetic wraps mod 2^XLEN.
// - ALU/illegal ops: IDLE->DONE. out_valid rises in cycle k+1.
// - MUL*: IDLE->MUL, one shift-add step per cycle, XLEN cycles, then ->DONE.
//   - out_valid rises in cycle k+1+XLEN.
//   - Signed operands use magnitudes; the 2*XLEN product is negated at the end if the signs differ.
//   - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
//   - MULHSU: a signed, b unsigned.
// - DIV*: IDLE->DIV, restoring, one quotient bit per cycle, XLEN cycles, then ->DONE.
//   - out_valid rises in cycle k+1+XLEN.
//   - Quotient sign = sign(a)^sign(b). Remainder sign = sign(a).
// - Divide fast paths (IDLE->DONE, out_valid at k+1):
//   - b==0: quotient = all ones, remainder = a.
//   - Signed a==MIN, b==-1: quotient = MIN, remainder = 0.
// - DONE: result, out_valid=1 and out_illegal are held stable until out_ready.
//   - On out_valid&&out_ready: ->IDLE and out_valid=0 next cycle.
//   - Throughput is therefore at most 1 op per 2 cycles.
// - out_ready is ignored when out_valid=0. in_valid is ignored outside IDLE.
// TESTING
// - ALUop=10, f7=0100000, f3=000, a=5, b=7 -> out_valid at k+1, result=32'hFFFFFFFE.
// - ALUop=11, f3=101, f7=0100000, a=32'h80000000, b=4 -> result=32'hF8000000.
//   - Same stimulus with f7=0000001 -> out_illegal=1, result=0.
// - MULH, a=32'hFFFFFFFF (-1), b=2 -> result=32'hFFFFFFFF at k+33.
//   - MULHU, same operands -> result=32'h00000001.
// - DIV, a=-7, b=2 -> q=-3 (32'hFFFFFFFD) at k+33. REM -> 32'hFFFFFFFF.
//   - DIVU, b=0 -> 32'hFFFFFFFF at k+1.
//   - DIV, a=32'h80000000, b=-1 -> 32'h80000000 at k+1.
// - Hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0.
//   - Then out_ready=1 -> in_ready=1 next cycle.
// - Assert rst at cycle k+10 of a DIV -> out_valid never rises.
//   - in_ready=1 after reset releases; next ADD completes correctly.

Source files
------------

// File: rtl/cayde_alu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : cayde_alu_mdu
// Description : Execute unit. Decodes ALUop/funct7/funct3, computes single-
//               cycle RV32I/RV64I integer ops and iterative M-extension
//               multiply/divide behind valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module cayde_alu_mdu #(
    parameter int XLEN  = 32,
    parameter bit M_EXT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUop,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            out_illegal
);
    localparam int               c_SHW  = $clog2(XLEN);
    localparam logic [c_SHW-1:0] c_LAST = c_SHW'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] c_OP_ADD  = 5'd0,  c_OP_SUB    = 5'd1,  c_OP_SLL   = 5'd2;
    localparam logic [4:0] c_OP_SLT  = 5'd3,  c_OP_SLTU   = 5'd4,  c_OP_XOR   = 5'd5;
    localparam logic [4:0] c_OP_SRL  = 5'd6,  c_OP_SRA    = 5'd7,  c_OP_OR    = 5'd8;
    localparam logic [4:0] c_OP_AND  = 5'd9,  c_OP_MUL    = 5'd10, c_OP_MULH  = 5'd11;
    localparam logic [4:0] c_OP_MULHSU = 5'd12, c_OP_MULHU = 5'd13, c_OP_DIV  = 5'd14;
    localparam logic [4:0] c_OP_DIVU = 5'd15, c_OP_REM    = 5'd16, c_OP_REMU  = 5'd17;
    localparam logic [4:0] c_OP_ILL  = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state, w_state_nx;
    logic [4:0]            w_op;
    logic [XLEN-1:0]       w_alu, w_a_mag, w_b_mag;
    logic [c_SHW-1:0]      w_shamt;
    logic                  w_is_mul, w_is_div, w_div_s, w_div_rem, w_mul_sa, w_mul_sb;
    logic                  w_bzero, w_ovf, w_div_fast, w_a_neg, w_b_neg;
    logic [c_SHW-1:0]      r_cnt;
    logic [XLEN-1:0]       r_result, r_mcand, r_quo, r_rem, r_dvsr;
    logic [2*XLEN-1:0]     r_prod;
    logic                  r_illegal, r_neg, r_rneg, r_sel;
    logic [XLEN:0]         w_sum, w_trial;
    logic [2*XLEN-1:0]     w_prod_nx, w_prod_s;
    logic [XLEN-1:0]       w_diff, w_rem_nx, w_quo_nx, w_mul_res, w_div_res;
    logic                  w_ge;

    // Decode ALUop/funct7/funct3 into an internal operation code
    always_comb begin
        w_op = c_OP_ILL;
        case (ALUop)
            2'b00: w_op = c_OP_ADD;
            2'b01: w_op = c_OP_SUB;
            2'b10: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0:    w_op = c_OP_ADD;
                        3'd1:    w_op = c_OP_SLL;
                        3'd2:    w_op = c_OP_SLT;
                        3'd3:    w_op = c_OP_SLTU;
                        3'd4:    w_op = c_OP_XOR;
                        3'd5:    w_op = c_OP_SRL;
                        3'd6:    w_op = c_OP_OR;
                        default: w_op = c_OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'd0)      w_op = c_OP_SUB;
                    else if (funct3 == 3'd5) w_op = c_OP_SRA;
                end else if (funct7 == 7'b0000001 && M_EXT) begin
                    case (funct3)
                        3'd0:    w_op = c_OP_MUL;
                        3'd1:    w_op = c_OP_MULH;
                        3'd2:    w_op = c_OP_MULHSU;
                        3'd3:    w_op = c_OP_MULHU;
                        3'd4:    w_op = c_OP_DIV;
                        3'd5:    w_op = c_OP_DIVU;
                        3'd6:    w_op = c_OP_REM;
                        default: w_op = c_OP_REMU;
                    endcase
                end
            end
            default: begin
                case (funct3)
                    3'd0:    w_op = c_OP_ADD;
                    3'd1:    w_op = (funct7 == 7'b0000000) ? c_OP_SLL : c_OP_ILL;
                    3'd2:    w_op = c_OP_SLT;
                    3'd3:    w_op = c_OP_SLTU;
                    3'd4:    w_op = c_OP_XOR;
                    3'd5:    w_op = (funct7 == 7'b0000000) ? c_OP_SRL :
                                    (funct7 == 7'b0100000) ? c_OP_SRA : c_OP_ILL;
                    3'd6:    w_op = c_OP_OR;
                    default: w_op = c_OP_AND;
                endcase
            end
        endcase
    end

    assign w_is_mul   = w_op inside {c_OP_MUL, c_OP_MULH, c_OP_MULHSU, c_OP_MULHU};
    assign w_is_div   = w_op inside {c_OP_DIV, c_OP_DIVU, c_OP_REM, c_OP_REMU};
    assign w_div_s    = w_op inside {c_OP_DIV, c_OP_REM};
    assign w_div_rem  = w_op inside {c_OP_REM, c_OP_REMU};
    assign w_mul_sa   = w_op inside {c_OP_MUL, c_OP_MULH, c_OP_MULHSU};
    assign w_mul_sb   = w_op inside {c_OP_MUL, c_OP_MULH};
    assign w_bzero    = (b == '0);
    assign w_ovf      = w_div_s && (a == c_MIN) && (b == '1);
    assign w_div_fast = w_is_div && (w_bzero || w_ovf);
    assign w_a_neg    = a[XLEN-1] & (w_is_mul ? w_mul_sa : w_div_s);
    assign w_b_neg    = b[XLEN-1] & (w_is_mul ? w_mul_sb : w_div_s);
    assign w_a_mag    = w_a_neg ? -a : a;
    assign w_b_mag    = w_b_neg ? -b : b;
    assign w_shamt    = b[c_SHW-1:0];

    // Single-cycle results, including the divide special cases and illegal (zero)
    always_comb begin
        w_alu = '0;
        case (w_op)
            c_OP_ADD:  w_alu = a + b;
            c_OP_SUB:  w_alu = a - b;
            c_OP_SLL:  w_alu = a << w_shamt;
            c_OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            c_OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (a < b)};
            c_OP_XOR:  w_alu = a ^ b;
            c_OP_SRL:  w_alu = a >> w_shamt;
            c_OP_SRA:  w_alu = $signed(a) >>> w_shamt;
            c_OP_OR:   w_alu = a | b;
            c_OP_AND:  w_alu = a & b;
            c_OP_DIV:  w_alu = w_bzero ? '1 : c_MIN;
            c_OP_DIVU: w_alu = '1;
            c_OP_REM:  w_alu = w_bzero ? a : '0;
            c_OP_REMU: w_alu = a;
            default:   w_alu = '0;
        endcase
    end

    // Shift-add multiply step; sign fix and half select applied on the final step
    assign w_sum     = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_nx = {w_sum, r_prod[XLEN-1:1]};
    assign w_prod_s  = r_neg ? -w_prod_nx : w_prod_nx;
    assign w_mul_res = r_sel ? w_prod_s[2*XLEN-1:XLEN] : w_prod_s[XLEN-1:0];

    // Restoring divide step; quotient sign from both operands, remainder from dividend
    assign w_trial   = {r_rem, r_quo[XLEN-1]};
    assign w_ge      = (w_trial >= {1'b0, r_dvsr});
    assign w_diff    = w_trial[XLEN-1:0] - r_dvsr;
    assign w_rem_nx  = w_ge ? w_diff : w_trial[XLEN-1:0];
    assign w_quo_nx  = {r_quo[XLEN-2:0], w_ge};
    assign w_div_res = r_sel ? (r_rneg ? -w_rem_nx : w_rem_nx)
                             : (r_neg  ? -w_quo_nx : w_quo_nx);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next-state: fast ops go straight to DONE, mul/div iterate XLEN steps
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_is_mul)                     w_state_nx = S_MUL;
                    else if (w_is_div && !w_div_fast) w_state_nx = S_DIV;
                    else                              w_state_nx = S_DONE;
                end
            end
            S_MUL, S_DIV: if (r_cnt == c_LAST) w_state_nx = S_DONE;
            S_DONE:       if (out_ready) w_state_nx = S_IDLE;
            default:      w_state_nx = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result  <= '0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
            r_prod    <= '0;
            r_mcand   <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvsr    <= '0;
            r_neg     <= 1'b0;
            r_rneg    <= 1'b0;
            r_sel     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_result  <= w_alu;
                        r_illegal <= (w_op == c_OP_ILL);
                        r_cnt     <= '0;
                        r_neg     <= w_a_neg ^ w_b_neg;
                        r_rneg    <= w_a_neg;
                        r_sel     <= w_is_mul ? (w_op != c_OP_MUL) : w_div_rem;
                        r_mcand   <= w_a_mag;
                        r_prod    <= {{XLEN{1'b0}}, w_b_mag};
                        r_quo     <= w_a_mag;
                        r_rem     <= '0;
                        r_dvsr    <= w_b_mag;
                    end
                end
                S_MUL: begin
                    r_prod <= w_prod_nx;
                    r_cnt  <= r_cnt + c_SHW'(1);
                    if (r_cnt == c_LAST) r_result <= w_mul_res;
                end
                S_DIV: begin
                    r_quo <= w_quo_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + c_SHW'(1);
                    if (r_cnt == c_LAST) r_result <= w_div_res;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign result      = r_result;
    assign out_illegal = r_illegal;

endmodule
`default_nettype wire
